// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Purpose:
//   Shares the single data-memory/MMIO port between two requesters:
//     port 0 - CPU MEM-stage load/store
//     port 1 - secondary master (DMA / debug copy engine)
//   A granted request is latched and drives the downstream port until the
//   cache drops miss.  The winner then receives a one-cycle ack, plus read
//   data for reads.  One idle (GAP) cycle separates consecutive accesses, so
//   downstream request/miss edge counters see each access exactly once.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   reqN_re / reqN_we   read / write request (write wins when both are high)
//   reqN_addr/_wdata    request operands, held stable until reqN_ack
//   reqN_rdata          last read data returned to port N (valid with ack)
//   reqN_ack            one-cycle completion pulse for port N
//   mem_addr/_wdata     downstream operands (latched; qualified by enables)
//   mem_we / mem_re     downstream enables, asserted only in BUSY
//   mem_rdata           downstream combinational read data
//   mem_miss            downstream stall
//   busy                access in flight
//
// Optional feature (define DMEM_ARB_PERF_EN):
//   grant_cnt0/1        grants issued to each port (wraps at 2^32)
//   wait_cnt0/1         cycles a port requests while not being served
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_re,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic [DW-1:0] req0_rdata,
  output logic          req0_ack,
  input  logic          req1_re,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic [DW-1:0] req1_rdata,
  output logic          req1_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_miss,
  output logic          busy
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]   grant_cnt0,
  output logic [31:0]   grant_cnt1,
  output logic [31:0]   wait_cnt0,
  output logic [31:0]   wait_cnt1
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]    r_state;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_we;
  logic          r_gnt;     // id of the port owning the current access
  logic          r_ptr;     // last-granted port; the opposite port wins a tie
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          r_ack0;
  logic          r_ack1;

  logic w_req0;
  logic w_req1;
  logic w_pick;
  logic w_grant;
  logic w_in_busy;

  assign w_req0    = req0_re | req0_we;
  assign w_req1    = req1_re | req1_we;
  // Tie goes to the port opposite the last grant; otherwise whoever asks.
  assign w_pick    = (w_req0 & w_req1) ? ~r_ptr : w_req1;
  assign w_grant   = (r_state == ST_IDLE) & (w_req0 | w_req1);
  assign w_in_busy = (r_state == ST_BUSY);

  // Downstream port is a direct decode of state and latched operands; the
  // operands stay put outside BUSY and only the enables qualify them.
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = w_in_busy & r_we;
  assign mem_re    = w_in_busy & ~r_we;
  assign busy      = w_in_busy;

  assign req0_rdata = r_rdata0;
  assign req1_rdata = r_rdata1;
  assign req0_ack   = r_ack0;
  assign req1_ack   = r_ack1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of all the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_gnt    <= 1'b0;
      r_ptr    <= 1'b1;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
    end else begin
      // Acks are single-cycle pulses unless re-armed below.
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state <= ST_BUSY;
            r_gnt   <= w_pick;
            r_ptr   <= w_pick;
            r_addr  <= w_pick ? req1_addr  : req0_addr;
            r_wdata <= w_pick ? req1_wdata : req0_wdata;
            r_we    <= w_pick ? req1_we    : req0_we;
          end
        end
        ST_BUSY: begin
          if (!mem_miss) begin
            r_state <= ST_GAP;
            if (r_gnt) begin
              r_ack1 <= 1'b1;
              if (!r_we) r_rdata1 <= mem_rdata;
            end else begin
              r_ack0 <= 1'b1;
              if (!r_we) r_rdata0 <= mem_rdata;
            end
          end
        end
        ST_GAP:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] r_grant_cnt0;
  logic [31:0] r_grant_cnt1;
  logic [31:0] r_wait_cnt0;
  logic [31:0] r_wait_cnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
      r_wait_cnt0  <= '0;
      r_wait_cnt1  <= '0;
    end else begin
      if (w_grant && !w_pick) r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
      if (w_grant &&  w_pick) r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
      // A port is waiting whenever it asks and is not the one being served.
      if (w_req0 && !(w_in_busy && !r_gnt)) r_wait_cnt0 <= r_wait_cnt0 + 32'd1;
      if (w_req1 && !(w_in_busy &&  r_gnt)) r_wait_cnt1 <= r_wait_cnt1 + 32'd1;
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
  assign wait_cnt0  = r_wait_cnt0;
  assign wait_cnt1  = r_wait_cnt1;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Directed scenarios followed by randomized traffic.  A transaction-level
// reference model (one in-flight access record, a cool-down flag after each
// completion, a last-winner bit) predicts every output each cycle.
// Perf-counter checks are included when DMEM_ARB_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_re, req0_we, req1_re, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic          req0_ack, req1_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_rdata;
  logic          mem_miss;
  logic          busy;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0]   grant_cnt0, grant_cnt1, wait_cnt0, wait_cnt1;
`endif

  always #5 clk = ~clk;

  dmem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_re    (req0_re),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_rdata (req0_rdata),
    .req0_ack   (req0_ack),
    .req1_re    (req1_re),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_rdata (req1_rdata),
    .req1_ack   (req1_ack),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .mem_miss   (mem_miss),
    .busy       (busy)
`ifdef DMEM_ARB_PERF_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
    .wait_cnt0  (wait_cnt0),
    .wait_cnt1  (wait_cnt1)
`endif
  );

  // ---------------- requester agents ----------------
  typedef struct {
    bit          pend;
    bit          re;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t ag[2];

  // ---------------- reference model ----------------
  // An access is "in flight" from the edge it is granted until the edge on
  // which the memory answers without a miss; the following cycle carries
  // the ack and is a mandatory cool-down with no new grant.
  bit          m_active;
  int          m_port;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  bit          m_cool;
  int          m_last;
  bit          m_granted[2];
  bit          e_ack[2];
  logic [31:0] e_rdata[2];
  logic [31:0] e_gcnt[2];
  logic [31:0] e_wcnt[2];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_port = 0; m_we = 0; m_addr = '0; m_wdata = '0;
    m_cool = 0; m_last = 1;
    for (int p = 0; p < 2; p++) begin
      m_granted[p] = 0; e_ack[p] = 0; e_rdata[p] = '0;
      e_gcnt[p] = '0; e_wcnt[p] = '0;
    end
  endtask

  task automatic model_step();
    bit r[2];
    int w;
    r[0] = req0_re | req0_we;
    r[1] = req1_re | req1_we;
    if (rst) begin
      model_reset();
      return;
    end
    for (int p = 0; p < 2; p++)
      if (r[p] && !(m_active && m_port == p)) e_wcnt[p] = e_wcnt[p] + 1;
    e_ack[0] = 0;
    e_ack[1] = 0;
    if (m_active) begin
      if (!mem_miss) begin
        if (!m_we) e_rdata[m_port] = mem_rdata;
        e_ack[m_port]     = 1;
        m_granted[m_port] = 0;
        m_active          = 0;
        m_cool            = 1;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else if (r[0] || r[1]) begin
      if (r[0] && r[1]) w = 1 - m_last;
      else              w = r[1] ? 1 : 0;
      m_last       = w;
      m_active     = 1;
      m_port       = w;
      m_we         = ag[w].we;
      m_addr       = ag[w].addr;
      m_wdata      = ag[w].wdata;
      m_granted[w] = 1;
      e_gcnt[w]    = e_gcnt[w] + 1;
    end
  endtask

  task automatic drive_inputs();
    req0_re    = ag[0].pend & ag[0].re;
    req0_we    = ag[0].pend & ag[0].we;
    req0_addr  = ag[0].addr;
    req0_wdata = ag[0].wdata;
    req1_re    = ag[1].pend & ag[1].re;
    req1_we    = ag[1].pend & ag[1].we;
    req1_addr  = ag[1].addr;
    req1_wdata = ag[1].wdata;
  endtask

  task automatic compare_all();
    check("busy",      busy,       m_active);
    check("mem_re",    mem_re,     m_active & ~m_we);
    check("mem_we",    mem_we,     m_active & m_we);
    check("mem_addr",  mem_addr,   m_addr);
    check("mem_wdata", mem_wdata,  m_wdata);
    check("ack0",      req0_ack,   e_ack[0]);
    check("ack1",      req1_ack,   e_ack[1]);
    check("rdata0",    req0_rdata, e_rdata[0]);
    check("rdata1",    req1_rdata, e_rdata[1]);
    check("two_acks",  req0_ack & req1_ack, 0);
`ifdef DMEM_ARB_PERF_EN
    check("grant_cnt0", grant_cnt0, e_gcnt[0]);
    check("grant_cnt1", grant_cnt1, e_gcnt[1]);
    check("wait_cnt0",  wait_cnt0,  e_wcnt[0]);
    check("wait_cnt1",  wait_cnt1,  e_wcnt[1]);
`endif
  endtask

  // One clock: apply current stimulus, advance model, sample #1 after edge.
  task automatic tick();
    drive_inputs();
    #1;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic set_req(input int p, input bit re, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    ag[p].pend = 1; ag[p].re = re; ag[p].we = we;
    ag[p].addr = addr; ag[p].wdata = wdata;
  endtask

  int          order[6];
  int          ack_cyc[6];
  int          nack;
  int          g1;
  int          exp_order[6];

  initial begin
    for (int p = 0; p < 2; p++) begin
      ag[p].pend = 0; ag[p].re = 0; ag[p].we = 0;
      ag[p].addr = '0; ag[p].wdata = '0;
    end
    model_reset();
    rst = 1; mem_miss = 0; mem_rdata = '0;
    @(negedge clk);
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_addr", mem_addr, 0);
    rst = 0;

    // --- port-0 read, zero miss ---
    set_req(0, 1, 0, 32'h0000_0040, '0);
    tick();                                   // T+1
    check("t1_re_T1", mem_re, 1);
    check("t1_addr_T1", mem_addr, 32'h0000_0040);
    mem_rdata = 32'h1234_5678;
    tick();                                   // T+2
    check("t1_ack_T2", req0_ack, 1);
    check("t1_rdata_T2", req0_rdata, 32'h1234_5678);
    check("t1_re_T2", mem_re, 0);
    ag[0].pend = 0;
    mem_rdata = 32'hFFFF_0000;
    tick();                                   // T+3
    check("t1_re_T3", mem_re, 0);
    check("t1_ack_T3", req0_ack, 0);

    // --- port-1 write with 5 miss cycles ---
    set_req(1, 0, 1, 32'h0000_0080, 32'hDEAD_BEEF);
    mem_miss = 1;
    tick();                                   // T+1
    for (int k = 0; k < 6; k++) begin         // T+1 .. T+6
      check("t2_we_hold", mem_we, 1);
      check("t2_addr_hold", mem_addr, 32'h0000_0080);
      check("t2_no_ack", req1_ack, 0);
      mem_miss = (k < 5);
      tick();
    end
    check("t2_ack_T7", req1_ack, 1);          // T+7
    check("t2_rdata_kept", req1_rdata, 0);
    ag[1].pend = 0;
    tick();
    check("t2_ack_pulse", req1_ack, 0);

    // --- re and we both high: write wins ---
    set_req(0, 1, 1, 32'h0000_0100, 32'h5555_AAAA);
    tick();
    check("t4_we", mem_we, 1);
    check("t4_re", mem_re, 0);
    check("t4_wdata", mem_wdata, 32'h5555_AAAA);
    tick();
    ag[0].pend = 0;
    tick();

    // --- reset during a miss stall ---
    set_req(0, 1, 0, 32'h0000_0200, '0);
    mem_miss = 1;
    tick();
    tick();
    check("t5_stall_busy", busy, 1);
    rst = 1;
    tick();
    check("t5_rst_busy", busy, 0);
    check("t5_rst_re", mem_re, 0);
    check("t5_rst_ack", req0_ack, 0);
    rst = 0;
    mem_miss = 0;
    tick();                                   // re-issued request granted
    check("t5_regrant", busy, 1);
    mem_rdata = 32'hCAFE_F00D;
    tick();
    check("t5_ack", req0_ack, 1);
    check("t5_rdata", req0_rdata, 32'hCAFE_F00D);
    ag[0].pend = 0;
    tick();

    // --- contention from reset: order 0,1,0,1 then port 0 alone twice ---
    rst = 1;
    tick();
    rst = 0;
    mem_miss = 0;
    set_req(0, 1, 0, 32'h0000_0A00, '0);
    set_req(1, 1, 0, 32'h0000_0B00, '0);
    nack = 0;
    g1 = 0;
    for (int c = 0; c < 80 && nack < 6; c++) begin
      mem_rdata = $urandom;
      tick();
      if (req0_ack && nack < 6) begin order[nack] = 0; ack_cyc[nack] = cyc; nack++; end
      if (req1_ack && nack < 6) begin
        order[nack] = 1; ack_cyc[nack] = cyc; nack++;
        g1++;
        if (g1 == 2) ag[1].pend = 0;
      end
    end
    check("t3_done", nack, 6);
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0;
    exp_order[3] = 1; exp_order[4] = 0; exp_order[5] = 0;
    for (int i = 0; i < nack; i++) check("t3_order", order[i], exp_order[i]);
    for (int i = 1; i < 4 && i < nack; i++) check("t3_spacing", ack_cyc[i] - ack_cyc[i-1], 3);
`ifdef DMEM_ARB_PERF_EN
    check("perf_grant0", grant_cnt0, 4);
    check("perf_grant1", grant_cnt1, 2);
`endif
    ag[0].pend = 0;
    tick();
    tick();

    // --- randomized traffic ---
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (e_ack[p]) ag[p].pend = 0;
        if (!ag[p].pend) begin
          if ($urandom_range(0, 2) == 0) begin
            int kind;
            kind = $urandom_range(0, 2);
            set_req(p, kind != 1, kind != 0, $urandom, $urandom);
          end
        end else if (!m_granted[p] && $urandom_range(0, 7) == 0) begin
          ag[p].pend = 0;                     // withdraw before grant
        end
      end
      mem_miss  = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      rst       = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
